fifo_rd_packer: RTL and testbench

//  Read-side drain stage directly downstream of async_fifo, in the rd_clk (25 MHz) domain.

---
 rtl/fifo_rd_packer.sv | 165 ++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Purpose  : Read-side drain stage for async_fifo. Pops lane-sized entries,
//             packs BYTES_PER_WORD of them into one word (first pop in lane 0)
//             and presents it on a valid/ready interface. Partial words are
//             emitted with a keep mask on flush request or idle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16,
  parameter int TO_WIDTH       = 8
) (
  input  logic                                 rd_clk,
  input  logic                                 rd_rst_n,
  output logic                                 fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 fifo_empty,
  input  logic                                 flush_req,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]            out_keep,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [15:0]                          words_out
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int WW = DATA_WIDTH * BYTES_PER_WORD;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [CW-1:0]       LAST_LANE = CW'(BYTES_PER_WORD - 1);
  localparam logic [CW:0]         WORD_LANES = (CW+1)'(BYTES_PER_WORD);
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic                TO_EN     = (TIMEOUT > 0);

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                inflight_q;
  logic                flush_pend_q, flush_pend_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [WW-1:0]       data_q, data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic [15:0]         words_q, words_d;

  logic          in_fill;
  logic          cnt_nz;
  logic [CW:0]   fill_level;
  logic          room;
  logic          idle;
  logic          to_hit;
  logic          flush_go;

  assign in_fill    = (state_q == S_FILL);
  assign cnt_nz     = (byte_cnt_q != '0);
  // Lanes already captured plus the one possibly still on its way from the FIFO.
  assign fill_level = {1'b0, byte_cnt_q} + {{CW{1'b0}}, inflight_q};
  assign room       = (fill_level < WORD_LANES);

  // Partial word sitting with nothing arriving: the condition the timeout measures.
  assign idle     = in_fill && cnt_nz && fifo_empty && !inflight_q;
  assign to_hit   = TO_EN && idle && (to_cnt_q == TO_LAST);
  // A flush can only close the word once no entry is in flight.
  assign flush_go = in_fill && cnt_nz && !inflight_q && (flush_req || flush_pend_q || to_hit);

  // Pop while there is space for one more lane. The pop is also held off on the
  // edge that closes a partial word, otherwise that entry would land in HOLD and
  // be lost. Reset forces the request low so nothing is popped during reset.
  assign fifo_rd_en = rd_rst_n && in_fill && !fifo_empty && room && !flush_go;

  assign out_valid = (state_q == S_HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign words_out = words_q;

  // Next-state: lane capture, word close (full or flushed), timeout and handshake.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    flush_pend_d = flush_pend_q;
    to_cnt_d     = to_cnt_q;
    data_d       = data_q;
    keep_d       = keep_q;
    words_d      = words_q;

    case (state_q)
      S_FILL: begin
        if (idle && !flush_go && TO_EN) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          to_cnt_d = '0;
        end

        if (inflight_q) begin
          for (int l = 0; l < BYTES_PER_WORD; l++) begin
            if (byte_cnt_q == CW'(l)) begin
              data_d[l*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_LANE) begin
            // Word completed by this capture; any pending flush is satisfied by it.
            state_d      = S_HOLD;
            keep_d       = '1;
            flush_pend_d = 1'b0;
          end else if (flush_req) begin
            // Defer the flush one edge so the entry being captured is included.
            flush_pend_d = 1'b1;
          end
        end else if (flush_go) begin
          state_d      = S_HOLD;
          flush_pend_d = 1'b0;
          for (int l = 0; l < BYTES_PER_WORD; l++) begin
            keep_d[l] = (CW'(l) < byte_cnt_q);
          end
        end
      end

      S_HOLD: begin
        to_cnt_d     = '0;
        flush_pend_d = 1'b0;
        if (out_ready) begin
          state_d    = S_FILL;
          byte_cnt_d = '0;
          keep_d     = '0;
          // Clear the buffer so unused lanes of the next partial word read as 0.
          data_d     = '0;
          words_d    = words_q + 16'd1;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= S_FILL;
      byte_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      to_cnt_q     <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      inflight_q   <= fifo_rd_en;
      flush_pend_q <= flush_pend_d;
      to_cnt_q     <= to_cnt_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      words_q      <= words_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Purpose  : Self-checking bench for fifo_rd_packer. A queue models the FIFO;
//             every accepted word must equal the entries popped since the
//             previous word, packed first-in to lane 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  localparam int DW      = 8;
  localparam int BPW     = 4;
  localparam int TIMEOUT = 16;

  logic            rd_clk = 1'b0;
  logic            rd_rst_n = 1'b0;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data = '0;
  logic            fifo_empty = 1'b1;
  logic            flush_req = 1'b0;
  logic [DW*BPW-1:0] out_data;
  logic [BPW-1:0]  out_keep;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     words_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  fq[$];
  logic [7:0]  popped_q[$];
  logic [31:0] acc_data[$];
  logic [3:0]  acc_keep[$];
  int          words_exp = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_d = '0;
  logic [3:0]  hold_k = '0;
  int          base;

  fifo_rd_packer #(
    .DATA_WIDTH     (DW),
    .BYTES_PER_WORD (BPW),
    .TIMEOUT        (TIMEOUT),
    .TO_WIDTH       (8)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .flush_req    (flush_req),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .words_out    (words_out)
  );

  // 25 MHz read clock
  always #20 rd_clk = ~rd_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] acc_d_at(input int i);
    return (acc_data.size() > i) ? acc_data[i] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] acc_k_at(input int i);
    return (acc_keep.size() > i) ? 32'(acc_keep[i]) : 32'hDEADBEEF;
  endfunction

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Reference: an accepted word holds every entry popped since the last word.
  task automatic score(input logic [31:0] d, input logic [3:0] k);
    int n;
    logic [31:0] ed;
    logic [3:0]  ek;
    n  = (popped_q.size() > BPW) ? BPW : popped_q.size();
    ed = '0;
    ek = '0;
    for (int i = 0; i < n; i++) begin
      ed[i*8 +: 8] = popped_q.pop_front();
      ek[i] = 1'b1;
    end
    check_eq("word_nonempty", 32'(n > 0), 32'd1);
    check_eq("word_data", d, ed);
    check_eq("word_keep", 32'(k), 32'(ek));
    words_exp = (words_exp + 1) & 32'hFFFF;
    check_eq("words_out", 32'(words_out), 32'(words_exp));
    acc_data.push_back(d);
    acc_keep.push_back(k);
  endtask

  // One clock: observe at negedge, advance, then apply FIFO model effects.
  task automatic cycle();
    logic pop, hs;
    logic [31:0] d;
    logic [3:0]  k;
    @(negedge rd_clk);
    if (hold_prev) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", out_data, hold_d);
      check_eq("hold_keep", 32'(out_keep), 32'(hold_k));
    end
    if (out_valid) check_eq("no_pop_in_hold", 32'(fifo_rd_en), 32'd0);
    pop = fifo_rd_en;
    hs  = out_valid & out_ready;
    d   = out_data;
    k   = out_keep;
    hold_prev = out_valid & ~out_ready;
    hold_d = d;
    hold_k = k;
    @(posedge rd_clk);
    #1;
    if (hs) score(d, k);
    if (pop) begin
      check_eq("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        fifo_rd_data = fq.pop_front();
        popped_q.push_back(fifo_rd_data);
      end
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic wait_acc(input string tag, input int target, input int max_cyc);
    int c;
    c = 0;
    while (acc_data.size() < target && c < max_cyc) begin
      cycle();
      c++;
    end
    check_eq(tag, 32'(acc_data.size()), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_data"}, out_data, 32'd0);
    check_eq({tag, "_keep"}, 32'(out_keep), 32'd0);
    check_eq({tag, "_words"}, 32'(words_out), 32'd0);
  endtask

  initial begin
    // 1: reset with FIFO preloaded, then two full words
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (2) @(posedge rd_clk);
    #1;
    check_reset_outputs("rst");
    rd_rst_n  = 1'b1;
    out_ready = 1'b1;
    wait_acc("t1_two_words", 2, 30);
    check_eq("t1_word0", acc_d_at(0), 32'h03020100);
    check_eq("t1_word1", acc_d_at(1), 32'h07060504);
    check_eq("t1_keep0", acc_k_at(0), 32'hF);
    check_eq("t1_keep1", acc_k_at(1), 32'hF);
    check_eq("t1_words_out", 32'(words_out), 32'd2);

    // 2: back-pressure holds the word; extra entry waits in the FIFO
    out_ready = 1'b0;
    base = acc_data.size();
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    for (int c = 0; c < 10 && !out_valid; c++) cycle();
    check_eq("t2_valid_rise", 32'(out_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      cycle();
      check_eq("t2_valid", 32'(out_valid), 32'd1);
      check_eq("t2_data", out_data, 32'h13121110);
      check_eq("t2_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check_eq("t2_once", 32'(acc_data.size()), 32'(base + 1));
    check_eq("t2_valid_drop", 32'(out_valid), 32'd0);
    check_eq("t2_words_out", 32'(words_out), 32'd3);
    out_ready = 1'b1;
    wait_acc("t2_tail", base + 2, TIMEOUT + 12);
    check_eq("t2_tail_keep", acc_k_at(base + 1), 32'h1);
    check_eq("t2_tail_data", acc_d_at(base + 1), 32'h00000014);

    // 3: explicit flush of a 3-entry partial word
    base = acc_data.size();
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) cycle();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    wait_acc("t3_flush_word", base + 1, 4);
    check_eq("t3_data", acc_d_at(base), 32'h00A3A2A1);
    check_eq("t3_keep", acc_k_at(base), 32'h7);

    // 4: idle timeout, out_valid rises 16 edges after the last capture
    out_ready = 1'b0;
    base = acc_data.size();
    push(8'hB1); push(8'hB2);
    for (int c = 1; c <= 19; c++) begin
      cycle();
      if (c == 18) check_eq("t4_not_early", 32'(out_valid), 32'd0);
      if (c == 19) check_eq("t4_rise", 32'(out_valid), 32'd1);
    end
    check_eq("t4_keep", 32'(out_keep), 32'h3);
    check_eq("t4_data", out_data, 32'h0000B2B1);
    out_ready = 1'b1;
    wait_acc("t4_accept", base + 1, 3);

    // 5: flush while the third entry is in flight, then flush with nothing held
    base = acc_data.size();
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (3) cycle();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    wait_acc("t5_pend_word", base + 1, 4);
    check_eq("t5_data", acc_d_at(base), 32'h00C3C2C1);
    check_eq("t5_keep", acc_k_at(base), 32'h7);
    base = acc_data.size();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    repeat (25) cycle();
    check_eq("t5_no_empty_word", 32'(acc_data.size()), 32'(base));
    check_eq("t5_idle_valid", 32'(out_valid), 32'd0);

    // 6: reset mid-word discards the partial word
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    repeat (3) cycle();
    rd_rst_n = 1'b0;
    fq.delete();
    popped_q.delete();
    fifo_empty = 1'b1;
    words_exp  = 0;
    hold_prev  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) cycle();
    rd_rst_n = 1'b1;
    base = acc_data.size();
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    wait_acc("t6_clean_word", base + 1, 12);
    check_eq("t6_data", acc_d_at(base), 32'h24232221);
    check_eq("t6_keep", acc_k_at(base), 32'hF);
    check_eq("t6_words_out", 32'(words_out), 32'd1);

    // Random traffic, back-pressure and flush pulses against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      if (fq.size() < 12 && $urandom_range(0, 1) == 1) push(8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush_req = 1'b0;
    out_ready = 1'b1;
    repeat (TIMEOUT + 30) cycle();
    check_eq("drain_fifo_left", 32'(fq.size()), 32'd0);
    check_eq("drain_bytes_left", 32'(popped_q.size()), 32'd0);
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
